aer_in_arbiter: RTL and testbench

//  Shares the core's AER input bus between two event sources: the pixel sorter
//  (req 0, rank-order encoded spikes) and the host/SPI injector (req 1).

---
 rtl/aer_in_arbiter_pkg.sv | 14 +
 rtl/aer_in_arbiter_if.sv | 29 ++
 rtl/aer_in_arbiter_ack_sync.sv | 23 ++
 rtl/aer_in_arbiter.sv | 160 ++++++++++++++++
 tb/tb_aer_in_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aer_in_arbiter_pkg.sv
// Shared types for the AER input arbiter.
// State encoding and source indices.
package aer_in_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } aer_arb_state_t;

  localparam logic SRC_SORTER = 1'b0;
  localparam logic SRC_HOST   = 1'b1;

endpackage

// File: rtl/aer_in_arbiter_if.sv
// Event-source and core-side AER signals of the input arbiter.
// slave = arbiter view, master = sources/core view.
interface aer_in_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              REQ0;
  logic [ADDR_W-1:0] ADDR0;
  logic              BUSY0;
  logic              REQ1;
  logic [ADDR_W-1:0] ADDR1;
  logic              BUSY1;
  logic [ADDR_W-1:0] AEROUT_ADDR;
  logic              AEROUT_REQ;
  logic              AEROUT_ACK;

  modport slave (
    input  REQ0, ADDR0, REQ1, ADDR1,
    input  AEROUT_ACK,
    output BUSY0, BUSY1,
    output AEROUT_ADDR, AEROUT_REQ
  );

  modport master (
    output REQ0, ADDR0, REQ1, ADDR1,
    output AEROUT_ACK,
    input  BUSY0, BUSY1,
    input  AEROUT_ADDR, AEROUT_REQ
  );
endinterface

// File: rtl/aer_in_arbiter_ack_sync.sv
// Two-flop synchronizer for the asynchronous AER acknowledge.
// Reset clears both stages.
module aer_ack_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ack,
  output logic o_ack_s
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_ack;
      r_sync <= r_meta;
    end
  end

  assign o_ack_s = r_sync;
endmodule

// File: rtl/aer_in_arbiter.sv
// Two-source AER input arbiter: one-entry holding registers,
// round-robin grant and a 4-phase REQ/ACK master with timeout.
module aer_in_arbiter
  import aer_in_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              CLK,
  input  logic              RSTN,
  aer_in_arbiter_if.slave   bus,
  input  logic              FLUSH,
  input  logic              CLR_ERR,
  output logic              OVF_ERR,
  output logic              TIMEOUT_ERR
);

  aer_arb_state_t    r_state;
  logic [TO_W-1:0]   r_cnt;
  logic [1:0]        r_pend;
  logic [1:0]        r_infl;
  logic [1:0]        r_busy;
  logic              r_last;
  logic              r_grant;
  logic [ADDR_W-1:0] r_addr0;
  logic [ADDR_W-1:0] r_addr1;
  logic [ADDR_W-1:0] r_aout_addr;
  logic              r_aout_req;
  logic              r_ovf;
  logic              r_to;

  logic              w_ack_s;
  logic [1:0]        w_req;
  logic              w_to_hit;
  logic              w_to_ev;
  logic              w_done;
  logic [1:0]        w_done_v;
  logic [1:0]        w_fl_mask;
  logic [1:0]        w_free;
  logic [1:0]        w_set;
  logic [1:0]        w_ovf;
  logic [1:0]        w_cand;
  logic              w_start;
  logic              w_g;
  logic [1:0]        w_start_v;
  logic [1:0]        w_pend_nxt;
  logic [1:0]        w_infl_nxt;

  aer_ack_sync u_ack_sync (
    .i_clk   (CLK),
    .i_rst_n (RSTN),
    .i_ack   (bus.AEROUT_ACK),
    .o_ack_s (w_ack_s)
  );

  assign w_req    = {bus.REQ1, bus.REQ0};
  assign w_to_hit = (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_to_ev   = 1'b0;
    w_done    = 1'b0;
    w_cand    = 2'b00;
    w_start   = 1'b0;
    w_g       = SRC_SORTER;
    w_start_v = 2'b00;
    w_done_v  = 2'b00;
    unique case (r_state)
      IDLE: begin
        // Flushed entries must not be granted on the flush edge
        w_cand  = r_pend & ~{2{FLUSH}};
        w_start = |w_cand;
        if (&w_cand)
          w_g = ~r_last;
        else
          w_g = w_cand[SRC_HOST] ? SRC_HOST : SRC_SORTER;
      end
      REQ_HI: w_to_ev = ~w_ack_s & w_to_hit;
      REQ_LO: begin
        w_to_ev = w_ack_s & w_to_hit;
        w_done  = ~w_ack_s | w_to_hit;
      end
      default: ;
    endcase
    if (w_start) w_start_v[w_g] = 1'b1;
    if (w_done) w_done_v[r_grant] = 1'b1;
  end

  // New strobes win over completion and flush on the same edge
  assign w_fl_mask  = FLUSH ? ~r_infl : 2'b00;
  assign w_free     = ~r_pend | w_done_v | w_fl_mask;
  assign w_set      = w_req & w_free;
  assign w_ovf      = w_req & ~w_free;
  assign w_pend_nxt = (r_pend & ~(w_done_v | w_fl_mask)) | w_set;
  assign w_infl_nxt = (r_infl & ~w_done_v) | w_start_v;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_pend      <= 2'b00;
      r_infl      <= 2'b00;
      r_busy      <= 2'b00;
      r_last      <= SRC_HOST;
      r_grant     <= SRC_SORTER;
      r_addr0     <= '0;
      r_addr1     <= '0;
      r_aout_addr <= '0;
      r_aout_req  <= 1'b0;
      r_ovf       <= 1'b0;
      r_to        <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_infl <= w_infl_nxt;
      r_busy <= w_pend_nxt | w_infl_nxt;
      if (w_set[0]) r_addr0 <= bus.ADDR0;
      if (w_set[1]) r_addr1 <= bus.ADDR1;
      r_ovf <= (r_ovf & ~CLR_ERR) | (|w_ovf);
      r_to  <= (r_to & ~CLR_ERR) | w_to_ev;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_start) begin
            r_state     <= REQ_HI;
            r_grant     <= w_g;
            r_last      <= w_g;
            r_aout_req  <= 1'b1;
            r_aout_addr <= w_g ? r_addr1 : r_addr0;
          end
        end
        REQ_HI: begin
          if (w_ack_s || w_to_hit) begin
            r_state    <= REQ_LO;
            r_aout_req <= 1'b0;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        REQ_LO: begin
          if (w_done) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.BUSY0       = r_busy[0];
  assign bus.BUSY1       = r_busy[1];
  assign bus.AEROUT_ADDR = r_aout_addr;
  assign bus.AEROUT_REQ  = r_aout_req;
  assign OVF_ERR         = r_ovf;
  assign TIMEOUT_ERR     = r_to;

endmodule

// File: tb/tb_aer_in_arbiter.sv
// Self-checking bench for aer_in_arbiter: directed vectors,
// handshake corner cases and a randomized run against a model.
module tb_aer_in_arbiter;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic RSTN = 1'b0;
  logic FLUSH = 1'b0;
  logic CLR_ERR = 1'b0;
  logic OVF_ERR;
  logic TIMEOUT_ERR;
  logic core_auto = 1'b0;
  logic core_ack = 1'b0;
  logic man_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] dq[$];

  aer_in_arbiter_if #(.ADDR_W(AW)) bus ();

  assign bus.AEROUT_ACK = core_auto ? core_ack : man_ack;

  aer_in_arbiter #(
    .ADDR_W(AW),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .CLK(clk),
    .RSTN(RSTN),
    .bus(bus),
    .FLUSH(FLUSH),
    .CLR_ERR(CLR_ERR),
    .OVF_ERR(OVF_ERR),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic busy(input int k);
    return (k == 0) ? bus.BUSY0 : bus.BUSY1;
  endfunction

  // Behavioural core: random ACK delays, logs every address it accepts
  initial begin
    logic [AW-1:0] got;
    bit ok;
    forever begin
      @(posedge clk); #1;
      if (core_auto && RSTN && bus.AEROUT_REQ && !core_ack) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        got = bus.AEROUT_ADDR;
        dq.push_back(got);
        core_ack = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
          @(posedge clk); #1;
          if (!bus.AEROUT_REQ) begin ok = 1'b1; break; end
          if (bus.AEROUT_ADDR !== got)
            chk("core_addr_stable", bus.AEROUT_ADDR, got);
        end
        chk("core_req_drop", ok, 1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        core_ack = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    RSTN = 1'b0;
    bus.REQ0 = 0; bus.REQ1 = 0;
    bus.ADDR0 = '0; bus.ADDR1 = '0;
    FLUSH = 0; CLR_ERR = 0; man_ack = 0;
    repeat (2) @(negedge clk);
    RSTN = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse(input logic r0, input logic [AW-1:0] a0,
                       input logic r1, input logic [AW-1:0] a1);
    @(negedge clk);
    bus.REQ0 = r0; bus.ADDR0 = a0;
    bus.REQ1 = r1; bus.ADDR1 = a1;
    @(negedge clk);
    bus.REQ0 = 0; bus.REQ1 = 0;
  endtask

  task automatic wait_req(input logic v, input int n, input string nm);
    bit ok = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.AEROUT_REQ === v) begin ok = 1; break; end
      @(negedge clk);
    end
    chk(nm, ok, 1);
  endtask

  task automatic wait_busy(input int k, input logic v, input int n,
                           input string nm);
    bit ok = 0;
    for (int i = 0; i < n; i++) begin
      if (busy(k) === v) begin ok = 1; break; end
      @(negedge clk);
    end
    chk(nm, ok, 1);
  endtask

  task automatic wait_dq(input int cnt, input int n, input string nm);
    bit ok = 0;
    for (int i = 0; i < n; i++) begin
      if (dq.size() >= cnt) begin ok = 1; break; end
      @(negedge clk);
    end
    chk(nm, ok, 1);
  endtask

  typedef struct {
    logic          r0;
    logic [AW-1:0] a0;
    logic          r1;
    logic [AW-1:0] a1;
    int            n;
    logic [AW-1:0] e0;
    logic [AW-1:0] e1;
  } vec_t;

  vec_t vt[6];

  // Random-run model: outstanding flag and expected address per source
  bit            m_out[2];
  logic [AW-1:0] m_exp[2];
  int            m_sent;

  task automatic rnd_cycle(input bit allow);
    logic [AW-1:0] a;
    int s;
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      if (m_out[k]) chk($sformatf("rnd_busy%0d", k), busy(k), 1);
    while (dq.size() > 0) begin
      a = dq.pop_front();
      s = int'(a[AW-1]);
      chk("rnd_src_pending", m_out[s], 1);
      chk("rnd_addr", a, m_exp[s]);
      m_out[s] = 0;
    end
    bus.REQ0 = 0; bus.REQ1 = 0;
    if (allow) begin
      for (int k = 0; k < 2; k++) begin
        if (!m_out[k] && !busy(k) && ($urandom_range(0, 2) == 0)) begin
          a = AW'($urandom_range(0, 511));
          a[AW-1] = k[0];
          m_exp[k] = a;
          m_out[k] = 1;
          m_sent++;
          if (k == 0) begin bus.REQ0 = 1; bus.ADDR0 = a; end
          else begin bus.REQ1 = 1; bus.ADDR1 = a; end
        end
      end
    end
  endtask

  initial begin
    int cnt;
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vt[0] = '{1, 10'h001, 1, 10'h2FF, 2, 10'h001, 10'h2FF};
    vt[1] = '{1, 10'h001, 1, 10'h2FF, 2, 10'h001, 10'h2FF};
    vt[2] = '{1, 10'h010, 0, 10'h000, 1, 10'h010, 10'h000};
    vt[3] = '{1, 10'h020, 1, 10'h321, 2, 10'h321, 10'h020};
    vt[4] = '{0, 10'h000, 1, 10'h1AB, 1, 10'h1AB, 10'h000};
    vt[5] = '{1, 10'h0F0, 1, 10'h30F, 2, 10'h0F0, 10'h30F};

    bus.REQ0 = 0; bus.REQ1 = 0;
    bus.ADDR0 = '0; bus.ADDR1 = '0;
    do_reset();

    chk("rst_req", bus.AEROUT_REQ, 0);
    chk("rst_addr", bus.AEROUT_ADDR, 0);
    chk("rst_busy0", bus.BUSY0, 0);
    chk("rst_busy1", bus.BUSY1, 0);
    chk("rst_ovf", OVF_ERR, 0);
    chk("rst_to", TIMEOUT_ERR, 0);

    // Single sorter event, manual ACK
    pulse(1, 10'h05A, 0, 10'h000);
    chk("t1_busy0_up", bus.BUSY0, 1);
    chk("t1_req_not_yet", bus.AEROUT_REQ, 0);
    @(negedge clk);
    chk("t1_req_t1", bus.AEROUT_REQ, 1);
    chk("t1_addr", bus.AEROUT_ADDR, 10'h05A);
    repeat (3) @(negedge clk);
    man_ack = 1;
    wait_req(0, 10, "t1_req_drop");
    chk("t1_busy0_held", bus.BUSY0, 1);
    repeat (2) @(negedge clk);
    man_ack = 0;
    wait_busy(0, 0, 10, "t1_busy0_fall");
    chk("t1_addr_hold", bus.AEROUT_ADDR, 10'h05A);

    // Round-robin table
    do_reset();
    core_auto = 1;
    dq.delete();
    for (int r = 0; r < 6; r++) begin
      pulse(vt[r].r0, vt[r].a0, vt[r].r1, vt[r].a1);
      wait_dq(vt[r].n, 80, $sformatf("rr%0d_deliver", r));
      wait_busy(0, 0, 40, $sformatf("rr%0d_idle0", r));
      wait_busy(1, 0, 40, $sformatf("rr%0d_idle1", r));
      chk($sformatf("rr%0d_count", r), dq.size(), vt[r].n);
      if (dq.size() > 0)
        chk($sformatf("rr%0d_first", r), dq.pop_front(), vt[r].e0);
      if (vt[r].n == 2 && dq.size() > 0)
        chk($sformatf("rr%0d_second", r), dq.pop_front(), vt[r].e1);
      dq.delete();
    end

    // Overflow while busy
    pulse(1, 10'h100, 0, 10'h000);
    chk("t3_busy0", bus.BUSY0, 1);
    chk("t3_ovf_before", OVF_ERR, 0);
    pulse(1, 10'h155, 0, 10'h000);
    chk("t3_ovf", OVF_ERR, 1);
    wait_dq(1, 60, "t3_deliver");
    wait_busy(0, 0, 40, "t3_idle");
    repeat (10) @(negedge clk);
    chk("t3_count", dq.size(), 1);
    if (dq.size() > 0) chk("t3_addr", dq.pop_front(), 10'h100);
    dq.delete();
    CLR_ERR = 1;
    @(negedge clk);
    CLR_ERR = 0;
    chk("t3_ovf_clr", OVF_ERR, 0);

    // Timeout with ACK held low
    core_auto = 0;
    man_ack = 0;
    pulse(1, 10'h0C3, 0, 10'h000);
    wait_req(1, 5, "t4_req_up");
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!bus.AEROUT_REQ) break;
      cnt++;
      @(negedge clk);
    end
    chk("t4_req_cycles", cnt, 15);
    chk("t4_to_err", TIMEOUT_ERR, 1);
    wait_busy(0, 0, 10, "t4_busy0_fall");
    chk("t4_req_low", bus.AEROUT_REQ, 0);
    CLR_ERR = 1;
    @(negedge clk);
    CLR_ERR = 0;
    chk("t4_to_clr", TIMEOUT_ERR, 0);

    // Flush drops the pending host entry only
    pulse(1, 10'h0AA, 0, 10'h000);
    wait_req(1, 5, "t5_req_up");
    pulse(0, 10'h000, 1, 10'h3CC);
    chk("t5_busy1", bus.BUSY1, 1);
    @(negedge clk);
    FLUSH = 1;
    @(negedge clk);
    FLUSH = 0;
    chk("t5_busy1_flushed", bus.BUSY1, 0);
    chk("t5_busy0_kept", bus.BUSY0, 1);
    chk("t5_req_kept", bus.AEROUT_REQ, 1);
    man_ack = 1;
    wait_req(0, 10, "t5_req_drop");
    man_ack = 0;
    wait_busy(0, 0, 10, "t5_busy0_fall");
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.AEROUT_REQ) cnt++;
    end
    chk("t5_no_host", cnt, 0);
    chk("t5_addr_hold", bus.AEROUT_ADDR, 10'h0AA);

    // Reset in the middle of a handshake
    pulse(1, 10'h011, 0, 10'h000);
    pulse(0, 10'h000, 1, 10'h222);
    wait_req(1, 5, "t6_req_up");
    RSTN = 0;
    #1;
    chk("t6_req_async", bus.AEROUT_REQ, 0);
    chk("t6_busy0_async", bus.BUSY0, 0);
    chk("t6_busy1_async", bus.BUSY1, 0);
    repeat (2) @(negedge clk);
    RSTN = 1;
    core_auto = 1;
    dq.delete();
    pulse(0, 10'h000, 1, 10'h2A5);
    wait_dq(1, 60, "t6_deliver");
    if (dq.size() > 0) chk("t6_addr", dq.pop_front(), 10'h2A5);
    wait_busy(1, 0, 40, "t6_idle");
    dq.delete();

    // Randomized traffic against the model
    m_out[0] = 0; m_out[1] = 0; m_sent = 0;
    for (int i = 0; i < 1500; i++) rnd_cycle(1);
    for (int i = 0; i < 200; i++) rnd_cycle(0);
    chk("rnd_drain0", m_out[0], 0);
    chk("rnd_drain1", m_out[1], 0);
    chk("rnd_some_sent", (m_sent > 50), 1);
    chk("rnd_ovf", OVF_ERR, 0);
    chk("rnd_to", TIMEOUT_ERR, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
